// File: rtl/es8156_i2c_responder.sv
// ES8156 control-port I2C target with an 8-bit-addressed register file for a host to inspect.
// Optional macro I2C_AUTOINC_EN: register pointer advances after each ACKed data byte (burst access).
module es8156_i2c_responder #(
  parameter logic [6:0]  DEV_ADDR  = 7'h09,
  parameter int unsigned REG_DEPTH = 64,
  parameter int unsigned FILT_LEN  = 3
) (
  input  logic       clk_12M,
  input  logic       rstn,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy
);

  localparam int unsigned AW  = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
  localparam int unsigned FCW = $clog2(FILT_LEN + 1);

`ifdef I2C_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_DEVADDR, S_DEV_ACK, S_REGADDR, S_REG_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_MACK, S_IGNORE
  } state_t;

  // Bit 1 carries SCL, bit 0 carries SDA through sync, filter and edge detect.
  logic [1:0]     sync1, sync2, filt, filt_q;
  logic [FCW-1:0] fcnt [2];

  always_ff @(posedge clk_12M or negedge rstn) begin
    if (!rstn) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      filt   <= 2'b11;
      filt_q <= 2'b11;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      sync1  <= {scl_i, sda_i};
      sync2  <= sync1;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FCW'(FILT_LEN - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + FCW'(1);
        end
      end
    end
  end

  logic scl_rise_c, scl_fall_c, start_c, stop_c;
  assign scl_rise_c = filt[1] & ~filt_q[1];
  assign scl_fall_c = ~filt[1] & filt_q[1];
  assign start_c    = filt[1] & filt_q[1] & filt_q[0] & ~filt[0];
  assign stop_c     = filt[1] & filt_q[1] & ~filt_q[0] & filt[0];

  state_t     state, state_nxt;
  logic [3:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic [7:0] ptr, ptr_nxt;
  logic       rw, rw_nxt;
  logic       sda_oe_nxt, busy_nxt, wr_en_nxt;
  logic [7:0] wr_addr_nxt, wr_data_nxt;
  logic       we_c;

  logic [7:0] regs [REG_DEPTH];

  logic       in_range_c;
  logic [7:0] rbyte_c, byte_in_c, ptr_inc_c;
  assign in_range_c = 32'(ptr) < REG_DEPTH;
  assign rbyte_c    = in_range_c ? regs[ptr[AW-1:0]] : 8'hFF;
  assign byte_in_c  = {shreg[6:0], filt[0]};
  assign ptr_inc_c  = AUTOINC ? ptr + 8'd1 : ptr;

  // Host port reads the array directly, so a same-cycle bus write shows next cycle.
  assign rd_data = (32'(rd_addr) < REG_DEPTH) ? regs[rd_addr[AW-1:0]] : 8'h00;

  always_ff @(posedge clk_12M or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < REG_DEPTH; i++) regs[i] <= 8'h00;
    end else if (we_c) begin
      regs[ptr[AW-1:0]] <= shreg;
    end
  end

  always_ff @(posedge clk_12M or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      ptr     <= '0;
      rw      <= 1'b0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      ptr     <= ptr_nxt;
      rw      <= rw_nxt;
      sda_oe  <= sda_oe_nxt;
      busy    <= busy_nxt;
      wr_en   <= wr_en_nxt;
      wr_addr <= wr_addr_nxt;
      wr_data <= wr_data_nxt;
    end
  end

  // Ack states use bit_cnt 8 = waiting to drive, 9 = driving until the next SCL fall.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    ptr_nxt     = ptr;
    rw_nxt      = rw;
    sda_oe_nxt  = sda_oe;
    busy_nxt    = busy;
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = wr_addr;
    wr_data_nxt = wr_data;
    we_c        = 1'b0;
    if (start_c) begin
      state_nxt   = S_DEVADDR;
      bit_cnt_nxt = '0;
      sda_oe_nxt  = 1'b0;
    end else if (stop_c) begin
      state_nxt   = S_IDLE;
      bit_cnt_nxt = '0;
      sda_oe_nxt  = 1'b0;
      busy_nxt    = 1'b0;
    end else begin
      case (state)
        S_IDLE: ;
        S_DEVADDR: if (scl_rise_c) begin
          shreg_nxt   = byte_in_c;
          bit_cnt_nxt = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            if (byte_in_c[7:1] == DEV_ADDR) begin
              state_nxt   = S_DEV_ACK;
              busy_nxt    = 1'b1;
              rw_nxt      = byte_in_c[0];
              bit_cnt_nxt = 4'd8;
            end else begin
              state_nxt = S_IGNORE;
            end
          end
        end
        S_DEV_ACK: if (scl_fall_c) begin
          if (bit_cnt == 4'd8) begin
            sda_oe_nxt  = 1'b1;
            bit_cnt_nxt = 4'd9;
          end else begin
            bit_cnt_nxt = '0;
            if (rw) begin
              state_nxt  = S_RDATA;
              shreg_nxt  = rbyte_c;
              sda_oe_nxt = ~rbyte_c[7];
            end else begin
              state_nxt  = S_REGADDR;
              sda_oe_nxt = 1'b0;
            end
          end
        end
        S_REGADDR: if (scl_rise_c) begin
          shreg_nxt   = byte_in_c;
          bit_cnt_nxt = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            ptr_nxt     = byte_in_c;
            state_nxt   = S_REG_ACK;
            bit_cnt_nxt = 4'd8;
          end
        end
        S_REG_ACK: if (scl_fall_c) begin
          if (bit_cnt == 4'd8) begin
            sda_oe_nxt  = 1'b1;
            bit_cnt_nxt = 4'd9;
          end else begin
            sda_oe_nxt  = 1'b0;
            state_nxt   = S_WDATA;
            bit_cnt_nxt = '0;
          end
        end
        S_WDATA: if (scl_rise_c) begin
          shreg_nxt   = byte_in_c;
          bit_cnt_nxt = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            state_nxt   = S_WDATA_ACK;
            bit_cnt_nxt = 4'd8;
          end
        end
        S_WDATA_ACK: if (scl_fall_c) begin
          if (bit_cnt == 4'd8) begin
            if (in_range_c) begin
              sda_oe_nxt  = 1'b1;
              wr_en_nxt   = 1'b1;
              wr_addr_nxt = ptr;
              wr_data_nxt = shreg;
              we_c        = 1'b1;
              ptr_nxt     = ptr_inc_c;
              bit_cnt_nxt = 4'd9;
            end else begin
              sda_oe_nxt = 1'b0;
              state_nxt  = S_IGNORE;
            end
          end else begin
            sda_oe_nxt  = 1'b0;
            state_nxt   = S_WDATA;
            bit_cnt_nxt = '0;
          end
        end
        S_RDATA: begin
          if (scl_rise_c) begin
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (scl_fall_c) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_nxt  = 1'b0;
              state_nxt   = S_MACK;
              bit_cnt_nxt = '0;
            end else if (bit_cnt != 4'd0) begin
              shreg_nxt  = {shreg[6:0], 1'b0};
              sda_oe_nxt = ~shreg[6];
            end
          end
        end
        S_MACK: begin
          if (scl_rise_c) begin
            if (!filt[0]) begin
              ptr_nxt     = ptr_inc_c;
              bit_cnt_nxt = 4'd1;
            end else begin
              state_nxt = S_IGNORE;
            end
          end else if (scl_fall_c && bit_cnt == 4'd1) begin
            state_nxt   = S_RDATA;
            bit_cnt_nxt = '0;
            shreg_nxt   = rbyte_c;
            sda_oe_nxt  = ~rbyte_c[7];
          end
        end
        S_IGNORE: sda_oe_nxt = 1'b0;
        default: begin
          state_nxt  = S_IDLE;
          sda_oe_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_es8156_i2c_responder.sv
// Bench for es8156_i2c_responder: bit-level I2C master, transaction-level register/pointer model.
`timescale 1ns/1ps
module tb_es8156_i2c_responder;

  localparam int HL = 6;
`ifdef I2C_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       clk_12M = 1'b0;
  logic       rstn, scl, sda_m;
  logic       sda_oe, wr_en, busy;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  wire        sda_bus = sda_m & ~sda_oe;

  es8156_i2c_responder dut (
    .clk_12M (clk_12M),
    .rstn    (rstn),
    .scl_i   (scl),
    .sda_i   (sda_bus),
    .sda_oe  (sda_oe),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy)
  );

  always #5 clk_12M = ~clk_12M;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  mreg [256];
  logic [7:0]  mptr;
  logic [15:0] wq [$];
  bit          quiet = 1'b0;
  int          force_addr = -1;
  logic [7:0]  wbuf [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_rd(input logic [7:0] a);
    return (a < 8'd64) ? mreg[a] : 8'h00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) mreg[i] = 8'h00;
    mptr = 8'h00;
    wq.delete();
  endtask

  // Per-cycle compare: write pulses against predicted queue, host port against model when idle.
  always @(negedge clk_12M) begin
    if (rstn === 1'b1) begin
      if (wr_en === 1'b1) begin
        if (wq.size() == 0) begin
          chk("wr_en_spurious", 32'(wr_en), 32'd0);
        end else begin
          logic [15:0] e;
          e = wq.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(e[15:8]));
          chk("wr_data", 32'(wr_data), 32'(e[7:0]));
        end
      end
      if (quiet) begin
        chk("rd_data", 32'(rd_data), 32'(model_rd(rd_addr)));
        chk("idle_sda_oe", 32'(sda_oe), 32'd0);
      end
    end
    rd_addr = (force_addr >= 0) ? 8'(force_addr) : 8'($urandom_range(0, 79));
  end

  initial begin
    #1500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk_12M);
  endtask

  task automatic bit_xfer(input logic b, input bit master_drives, input bit glitch, output logic s);
    if (glitch) begin
      wclk(2); scl = 1'b1; wclk(1); scl = 1'b0; wclk(HL - 3);
    end else begin
      wclk(HL);
    end
    sda_m = b;
    wclk(HL); scl = 1'b1;
    wclk(HL); s = sda_bus;
    if (master_drives) chk("target_released", 32'(sda_oe), 32'd0);
    wclk(HL); scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], 1'b1, i == glitch_bit, s);
    bit_xfer(1'b1, 1'b0, 1'b0, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, 1'b0, 1'b0, s);
      d[i] = s;
    end
    bit_xfer(~mack, 1'b1, 1'b0, s);
  endtask

  task automatic i2c_start();
    quiet = 1'b0;
    if (scl == 1'b1) begin
      wclk(2 * HL);
    end else begin
      wclk(HL); sda_m = 1'b1; wclk(HL); scl = 1'b1; wclk(2 * HL);
    end
    sda_m = 1'b0; wclk(2 * HL); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wclk(HL); sda_m = 1'b0; wclk(HL); scl = 1'b1; wclk(2 * HL); sda_m = 1'b1; wclk(2 * HL);
    wclk(10);
    chk("busy_after_stop", 32'(busy), 32'd0);
    chk("sda_oe_after_stop", 32'(sda_oe), 32'd0);
    quiet = 1'b1;
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
    force_addr = int'(a);
    wclk(2);
    #1;
    chk(name, 32'(rd_data), 32'(exp));
    force_addr = -1;
  endtask

  task automatic do_write(input logic [7:0] ra, input int n, input int glitch_bit);
    logic ack;
    bit   inr;
    i2c_start();
    write_byte(8'h12, -1, ack);
    chk("dev_ack", 32'(ack), 32'd1);
    chk("busy_matched", 32'(busy), 32'd1);
    write_byte(ra, -1, ack);
    chk("reg_ack", 32'(ack), 32'd1);
    mptr = ra;
    for (int i = 0; i < n; i++) begin
      inr = (mptr < 8'd64);
      if (inr) wq.push_back({mptr, wbuf[i]});
      write_byte(wbuf[i], (i == 0) ? glitch_bit : -1, ack);
      chk("data_ack", 32'(ack), 32'(inr));
      if (!inr) break;
      mreg[mptr] = wbuf[i];
      if (AUTOINC) mptr = mptr + 8'd1;
    end
    i2c_stop();
  endtask

  task automatic do_read(input bit set_addr, input logic [7:0] ra, input int n,
                         output logic [7:0] last_d);
    logic       ack;
    logic [7:0] d, e;
    i2c_start();
    if (set_addr) begin
      write_byte(8'h12, -1, ack);
      chk("dev_ack", 32'(ack), 32'd1);
      write_byte(ra, -1, ack);
      chk("reg_ack", 32'(ack), 32'd1);
      mptr = ra;
      i2c_start();
    end
    write_byte(8'h13, -1, ack);
    chk("rdev_ack", 32'(ack), 32'd1);
    chk("busy_matched", 32'(busy), 32'd1);
    d = 8'h00;
    for (int i = 0; i < n; i++) begin
      e = (mptr < 8'd64) ? mreg[mptr] : 8'hFF;
      read_byte(i != n - 1, d);
      chk("rd_byte", 32'(d), 32'(e));
      if (i != n - 1 && AUTOINC) mptr = mptr + 8'd1;
    end
    last_d = d;
    wclk(HL);
    chk("rel_after_nack", 32'(sda_oe), 32'd0);
    i2c_stop();
  endtask

  task automatic do_bad(input logic [7:0] dev);
    logic ack;
    i2c_start();
    write_byte(dev, -1, ack);
    chk("bad_dev_nack", 32'(ack), 32'd0);
    chk("bad_busy", 32'(busy), 32'd0);
    write_byte(8'h33, -1, ack);
    chk("bad_data_nack", 32'(ack), 32'd0);
    chk("bad_busy2", 32'(busy), 32'd0);
    i2c_stop();
  endtask

  initial begin
    logic       ack;
    logic [7:0] d, ra, dev;
    logic       s;
    rstn = 1'b0; scl = 1'b1; sda_m = 1'b1;
    model_reset();
    wclk(5);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rd_chk("rst_rd_data", 8'h00, 8'h00);
    rstn = 1'b1;
    wclk(5);
    quiet = 1'b1;

    // Single write then host readback.
    wbuf[0] = 8'h2A;
    do_write(8'h20, 1, -1);
    rd_chk("rd_20", 8'h20, 8'h2A);

    // Write then repeated-START read of the current pointer.
    i2c_start();
    write_byte(8'h12, -1, ack); chk("wr_dev_ack", 32'(ack), 32'd1);
    write_byte(8'h20, -1, ack); chk("wr_reg_ack", 32'(ack), 32'd1);
    mptr = 8'h20;
    wq.push_back({8'h20, 8'h2A});
    write_byte(8'h2A, -1, ack); chk("wr_data_ack", 32'(ack), 32'd1);
    mreg[8'h20] = 8'h2A;
    if (AUTOINC) mptr = mptr + 8'd1;
    i2c_start();
    write_byte(8'h13, -1, ack); chk("sr_dev_ack", 32'(ack), 32'd1);
    read_byte(1'b0, d);
    chk("sr_read_lit", 32'(d), AUTOINC ? 32'h00 : 32'h2A);
    wclk(HL);
    chk("sr_rel_after_nack", 32'(sda_oe), 32'd0);
    i2c_stop();

    do_bad(8'h14);

    // Burst of two bytes starting at 0x3E.
    wbuf[0] = 8'hAA; wbuf[1] = 8'hBB;
    do_write(8'h3E, 2, -1);
    rd_chk("burst_3e", 8'h3E, AUTOINC ? 8'hAA : 8'hBB);
    rd_chk("burst_3f", 8'h3F, AUTOINC ? 8'hBB : 8'h00);

    wbuf[0] = 8'h77;
    do_write(8'h50, 1, -1);
    rd_chk("oor_50", 8'h50, 8'h00);

    // One-cycle SCL glitch inside the data byte.
    wbuf[0] = 8'hC3;
    do_write(8'h05, 1, 3);
    rd_chk("glitch_05", 8'h05, 8'hC3);

    // Reset in the middle of a read that is driving zeros.
    wbuf[0] = 8'h00;
    do_write(8'h10, 1, -1);
    rd_chk("pre_reset_20", 8'h20, 8'h2A);
    i2c_start();
    write_byte(8'h12, -1, ack); chk("rr_dev_ack", 32'(ack), 32'd1);
    write_byte(8'h10, -1, ack); chk("rr_reg_ack", 32'(ack), 32'd1);
    i2c_start();
    write_byte(8'h13, -1, ack); chk("rr_rdev_ack", 32'(ack), 32'd1);
    bit_xfer(1'b1, 1'b0, 1'b0, s); chk("rr_bit7", 32'(s), 32'd0);
    bit_xfer(1'b1, 1'b0, 1'b0, s); chk("rr_bit6", 32'(s), 32'd0);
    wclk(HL); wclk(HL); scl = 1'b1; wclk(HL);
    chk("rr_driving", 32'(sda_oe), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("rr_async_release", 32'(sda_oe), 32'd0);
    chk("rr_busy_cleared", 32'(busy), 32'd0);
    sda_m = 1'b1; scl = 1'b1;
    wclk(4);
    rstn = 1'b1;
    model_reset();
    wclk(10);
    quiet = 1'b1;
    rd_chk("post_reset_20", 8'h20, 8'h00);
    rd_chk("post_reset_10", 8'h10, 8'h00);
    wbuf[0] = 8'h5A;
    do_write(8'h07, 1, -1);
    rd_chk("post_reset_07", 8'h07, 8'h5A);

    // Randomized mix of writes, reads (with and without address phase) and foreign addresses.
    for (int t = 0; t < 30; t++) begin
      int kind, sel, n;
      kind = int'($urandom_range(0, 9));
      sel  = int'($urandom_range(0, 3));
      n    = int'($urandom_range(1, 3));
      case (sel)
        0, 1:    ra = 8'($urandom_range(0, 63));
        2:       ra = 8'($urandom_range(56, 72));
        default: ra = 8'($urandom_range(250, 255));
      endcase
      for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom_range(0, 255));
      if (kind < 5) begin
        do_write(ra, n, -1);
      end else if (kind < 9) begin
        do_read($urandom_range(0, 3) != 0, ra, n, d);
      end else begin
        dev = 8'($urandom_range(0, 255));
        if (dev[7:1] == 7'h09) dev = dev ^ 8'h80;
        do_bad(dev);
      end
    end

    wclk(20);
    chk("wq_drained", 32'(wq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
